// File: rtl/cmd_rank_arbiter.sv
// rtl/cmd_rank_arbiter.sv - shared CMD bus arbiter across ranks with turnaround spacing and burst limiting
module cmd_rank_arbiter #(
    parameter int NUM_RANK  = 4,
    parameter int tRTRS     = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_RANK-1:0]         req,
    output logic [NUM_RANK-1:0]         grant,
    output logic                        grantValid,
    output logic [$clog2(NUM_RANK)-1:0] grantRank,
    output logic                        rankTransition,
    output logic                        cmdTurnaroundFree
);

    localparam int RW = $clog2(NUM_RANK);
    localparam int IW = $clog2(tRTRS + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    localparam logic [IW-1:0] IDLE_MAX  = IW'(tRTRS);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    typedef enum logic {
        ARB  = 1'b0,
        TURN = 1'b1
    } fsm_t;

    fsm_t          fsm;
    fsm_t          fsmNext;
    logic [RW-1:0] lastRank;
    logic          lastValid;
    logic [RW-1:0] target;
    logic [IW-1:0] idleCnt;
    logic [BW-1:0] burstCnt;

    logic          turnFree;
    logic          othersReq;
    logic          keepLast;
    logic [RW-1:0] startIdx;
    logic [RW-1:0] scanIdx;
    logic [RW-1:0] rrRank;
    logic          rrFound;
    logic [RW-1:0] winner;
    logic          winnerValid;

    logic          grantNow;
    logic [RW-1:0] grantIdx;
    logic          rtNow;
    logic          latchTarget;
    logic          grantFire;

    assign turnFree  = !lastValid || (idleCnt == IDLE_MAX);
    assign othersReq = |(req & ~(NUM_RANK'(1) << lastRank));
    assign keepLast  = lastValid && req[lastRank] && ((burstCnt < BURST_MAX) || !othersReq);
    assign startIdx  = lastValid ? lastRank + RW'(1) : '0;

    // Round-robin scan; index arithmetic wraps naturally because NUM_RANK is a power of two.
    always_comb begin
        rrFound = 1'b0;
        rrRank  = '0;
        scanIdx = '0;
        for (int k = 0; k < NUM_RANK; k++) begin
            scanIdx = startIdx + RW'(k);
            if (!rrFound && req[scanIdx]) begin
                rrFound = 1'b1;
                rrRank  = scanIdx;
            end
        end
    end

    assign winner      = keepLast ? lastRank : rrRank;
    assign winnerValid = keepLast || rrFound;

    always_comb begin
        fsmNext     = fsm;
        grantNow    = 1'b0;
        grantIdx    = '0;
        rtNow       = 1'b0;
        latchTarget = 1'b0;
        case (fsm)
            ARB: begin
                if (winnerValid) begin
                    if (!lastValid || (winner == lastRank) || turnFree) begin
                        grantNow = 1'b1;
                        grantIdx = winner;
                    end else begin
                        rtNow       = 1'b1;
                        latchTarget = 1'b1;
                        fsmNext     = TURN;
                    end
                end
            end
            TURN: begin
                // Requests are ignored until the turnaround window has fully elapsed.
                if (turnFree) begin
                    fsmNext = ARB;
                    if (req[target]) begin
                        grantNow = 1'b1;
                        grantIdx = target;
                    end
                end
            end
            default: fsmNext = ARB;
        endcase
    end

    assign grantFire         = grantNow && !rst;
    assign grant             = grantFire ? (NUM_RANK'(1) << grantIdx) : '0;
    assign grantValid        = grantFire;
    assign grantRank         = grantFire ? grantIdx : '0;
    assign rankTransition    = rtNow && !rst;
    assign cmdTurnaroundFree = turnFree;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= ARB;
            lastRank  <= '0;
            lastValid <= 1'b0;
            target    <= '0;
            idleCnt   <= IDLE_MAX;
            burstCnt  <= '0;
        end else begin
            fsm <= fsmNext;
            if (latchTarget) begin
                target <= winner;
            end
            if (grantFire) begin
                idleCnt   <= '0;
                lastRank  <= grantIdx;
                lastValid <= 1'b1;
                if (lastValid && (grantIdx == lastRank)) begin
                    burstCnt <= (burstCnt == BURST_MAX) ? burstCnt : burstCnt + BW'(1);
                end else begin
                    burstCnt <= BW'(1);
                end
            end else if (idleCnt != IDLE_MAX) begin
                idleCnt <= idleCnt + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cmd_rank_arbiter.sv
// tb/tb_cmd_rank_arbiter.sv - scoreboard bench for cmd_rank_arbiter against a timestamp-based model
module tb_cmd_rank_arbiter;

    localparam int N  = 4;
    localparam int T  = 2;
    localparam int MB = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] grant;
    logic         grantValid;
    logic [1:0]   grantRank;
    logic         rankTransition;
    logic         cmdTurnaroundFree;

    cmd_rank_arbiter #(.NUM_RANK(N), .tRTRS(T), .MAX_BURST(MB)) dut (
        .clk              (clk),
        .rst              (rst),
        .req              (req),
        .grant            (grant),
        .grantValid       (grantValid),
        .grantRank        (grantRank),
        .rankTransition   (rankTransition),
        .cmdTurnaroundFree(cmdTurnaroundFree)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] g;
        logic [1:0]   r;
        logic         rt;
        logic         tf;
        logic [N-1:0] rq;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model: history kept as cycle timestamps rather than counters.
    int mCyc          = 0;
    int mLastRank     = 0;
    bit mLastValid    = 0;
    int mLastGrantCyc = 0;
    int mBurst        = 0;
    bit mInTurn       = 0;
    int mTarget       = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic stepCycle(input logic [N-1:0] r, input logic rs, output int gr);
        exp_t e;
        int   w;
        int   st;
        bit   free;
        bit   others;
        @(posedge clk);
        #1;
        req = r;
        rst = rs;
        e.g = '0; e.r = '0; e.rt = 1'b0; e.tf = 1'b1; e.rq = r;
        gr = -1;
        if (rs) begin
            mLastValid = 0; mLastRank = 0; mBurst = 0; mInTurn = 0; mTarget = 0;
        end else begin
            free = !mLastValid || (mCyc - mLastGrantCyc - 1 >= T);
            e.tf = free;
            if (!mInTurn) begin
                w = -1;
                others = 0;
                for (int i = 0; i < N; i++) if (i != mLastRank && r[i]) others = 1;
                if (mLastValid && r[mLastRank] && (mBurst < MB || !others)) begin
                    w = mLastRank;
                end else begin
                    st = mLastValid ? mLastRank + 1 : 0;
                    for (int k = 0; k < N; k++) if (w < 0 && r[(st + k) % N]) w = (st + k) % N;
                end
                if (w >= 0) begin
                    if (!mLastValid || w == mLastRank || free) gr = w;
                    else begin
                        e.rt = 1'b1; mTarget = w; mInTurn = 1;
                    end
                end
            end else if (free) begin
                mInTurn = 0;
                if (r[mTarget]) gr = mTarget;
            end
            if (gr >= 0) begin
                mBurst = (mLastValid && gr == mLastRank) ? ((mBurst < MB) ? mBurst + 1 : MB) : 1;
                mLastRank = gr;
                mLastValid = 1;
                mLastGrantCyc = mCyc;
                e.g = N'(1) << gr;
                e.r = 2'(gr);
            end
        end
        mCyc++;
        sbQ.push_back(e);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) begin
                exp_t e;
                e = sbQ.pop_front();
                check("grant", int'(grant), int'(e.g));
                check("grantValid", int'(grantValid), int'(|e.g));
                check("grantRank", int'(grantRank), int'(e.r));
                check("rankTransition", int'(rankTransition), int'(e.rt));
                check("cmdTurnaroundFree", int'(cmdTurnaroundFree), int'(e.tf));
                check("grant_without_req", int'(grant & ~e.rq), 0);
                check("transition_with_grant", int'(rankTransition & grantValid), 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int           g;
        int           lastGr;
        int           rstLeft;
        logic [N-1:0] rr;
        // Reset then idle
        stepCycle(4'b0000, 1'b1, g);
        stepCycle(4'b0000, 1'b1, g);
        repeat (5) stepCycle(4'b0000, 1'b0, g);
        // Single requester streams
        repeat (6) stepCycle(4'b0001, 1'b0, g);
        // Switch to rank1: transition, two idle cycles, grant
        repeat (4) stepCycle(4'b0010, 1'b0, g);
        // Burst limiting between two ranks, starting from lastRank=0 burst=1
        stepCycle(4'b0000, 1'b1, g);
        stepCycle(4'b0001, 1'b0, g);
        repeat (24) stepCycle(4'b0011, 1'b0, g);
        // Target drops its request mid-turnaround
        stepCycle(4'b0000, 1'b1, g);
        stepCycle(4'b0001, 1'b0, g);
        repeat (2) stepCycle(4'b0100, 1'b0, g);
        repeat (2) stepCycle(4'b0000, 1'b0, g);
        repeat (2) stepCycle(4'b0010, 1'b0, g);
        // Reset during a turnaround
        stepCycle(4'b0001, 1'b0, g);
        stepCycle(4'b0010, 1'b0, g);
        stepCycle(4'b0010, 1'b1, g);
        repeat (2) stepCycle(4'b0100, 1'b0, g);
        // Randomized traffic with occasional resets
        rr = '0;
        lastGr = -1;
        rstLeft = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rstLeft == 0 && $urandom_range(0, 299) == 0) rstLeft = $urandom_range(1, 2);
            for (int b = 0; b < N; b++) begin
                if (lastGr == b && $urandom_range(0, 1) == 1) rr[b] = 1'b0;
                else if (rr[b]) begin
                    if ($urandom_range(0, 15) == 0) rr[b] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) rr[b] = 1'b1;
            end
            stepCycle(rr, rstLeft > 0, lastGr);
            if (rstLeft > 0) rstLeft--;
        end
        for (int i = 0; i < 10 && sbQ.size() > 0; i++) @(posedge clk);
        checks++;
        if (sbQ.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending expected 0", sbQ.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
